// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - defaults and channel-index width helper for the programmable clock divider
package clkdiv_pkg;

    localparam int DEF_NCH     = 4;
    localparam int DEF_DIV_W   = 8;
    localparam int DEF_DEF_DIV = 4;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// rtl/clkdiv_chan.sv - one divider channel: counter, live/shadow divisor, tick and square-wave outputs
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int DIV_W   = DEF_DIV_W,
    parameter int DEF_DIV = DEF_DEF_DIV
) (
    input  logic             hclkin,
    input  logic             reset,
    input  logic             en,
    input  logic             calib,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    output logic             tick,
    output logic             clkout,
    output logic             pend
);

    logic [DIV_W-1:0] cnt, div_cur, div_new;
    logic [DIV_W-1:0] cnt_nxt, div_cur_nxt, div_new_nxt;
    logic             pend_nxt, tick_nxt, clkout_nxt, wrap;
    logic [DIV_W:0]   half;

    always_comb begin
        cnt_nxt     = cnt;
        div_cur_nxt = div_cur;
        div_new_nxt = div_new;
        pend_nxt    = pend;
        tick_nxt    = 1'b0;
        clkout_nxt  = clkout;
        wrap        = 1'b0;
        half        = '0;
        if (calib) begin
            cnt_nxt    = '0;
            clkout_nxt = 1'b0;
            if (pend) begin
                div_cur_nxt = div_new;
                pend_nxt    = 1'b0;
            end
        end else if (en) begin
            if (div_cur == '0) begin
                cnt_nxt    = '0;
                clkout_nxt = 1'b0;
                if (pend) begin
                    div_cur_nxt = div_new;
                    pend_nxt    = 1'b0;
                end
            end else begin
                wrap     = (cnt >= div_cur - DIV_W'(1));
                cnt_nxt  = wrap ? '0 : cnt + DIV_W'(1);
                tick_nxt = wrap;
                // a divisor only swaps in at a wrap so no period is ever cut short
                if (wrap && pend) begin
                    div_cur_nxt = div_new;
                    pend_nxt    = 1'b0;
                end
                half       = ({1'b0, div_cur_nxt} + (DIV_W+1)'(1)) >> 1;
                clkout_nxt = ({1'b0, cnt_nxt} < half);
            end
        end
        // load is only offered while pend is clear, so it never races an apply
        if (load) begin
            div_new_nxt = load_div;
            pend_nxt    = 1'b1;
        end
    end

    always_ff @(posedge hclkin) begin
        if (reset) begin
            cnt     <= '0;
            div_cur <= DIV_W'(DEF_DIV);
            div_new <= '0;
            pend    <= 1'b0;
            tick    <= 1'b0;
            clkout  <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            div_cur <= div_cur_nxt;
            div_new <= div_new_nxt;
            pend    <= pend_nxt;
            tick    <= tick_nxt;
            clkout  <= clkout_nxt;
        end
    end

endmodule

// File: rtl/clkdiv_prog.sv
// rtl/clkdiv_prog.sv - multi-channel programmable divider top: cfg decode and ready mux
module clkdiv_prog
    import clkdiv_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int DIV_W   = DEF_DIV_W,
    parameter int DEF_DIV = DEF_DEF_DIV
) (
    input  logic                      hclkin,
    input  logic                      reset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [ch_width(NCH)-1:0]  cfg_ch,
    input  logic [DIV_W-1:0]          cfg_div,
    input  logic                      calib,
    input  logic [NCH-1:0]            en,
    output logic [NCH-1:0]            tick,
    output logic [NCH-1:0]            clkout,
    output logic [NCH-1:0]            pend
);

    localparam int CH_W = ch_width(NCH);

    // out-of-range channels stay ready so their transfers are swallowed
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CH_W'(i)) cfg_ready = ~pend[i];
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        logic load;
        assign load = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));

        clkdiv_chan #(
            .DIV_W  (DIV_W),
            .DEF_DIV(DEF_DIV)
        ) u_chan (
            .hclkin  (hclkin),
            .reset   (reset),
            .en      (en[g]),
            .calib   (calib),
            .load    (load),
            .load_div(cfg_div),
            .tick    (tick[g]),
            .clkout  (clkout[g]),
            .pend    (pend[g])
        );
    end

endmodule

// File: tb/tb_clkdiv_prog.sv
// tb/tb_clkdiv_prog.sv - directed self-checking bench for clkdiv_prog
module tb_clkdiv_prog;

    logic       hclkin = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       calib;
    logic [3:0] en;
    logic [3:0] tick;
    logic [3:0] clkout;
    logic [3:0] pend;

    int checks   = 0;
    int failures = 0;

    clkdiv_prog #(.NCH(4), .DIV_W(8), .DEF_DIV(4)) dut (
        .hclkin   (hclkin),
        .reset    (reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .calib    (calib),
        .en       (en),
        .tick     (tick),
        .clkout   (clkout),
        .pend     (pend)
    );

    always #5 hclkin = ~hclkin;

    task automatic cyc();
        @(posedge hclkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input int ch, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick[ch] && n < 64);
    endtask

    task automatic rec(input int n, input int a, input int b,
                       output logic [15:0] ta, output logic [15:0] ca,
                       output logic [15:0] tb, output logic [15:0] cb);
        ta = '0; ca = '0; tb = '0; cb = '0;
        for (int i = 0; i < n; i++) begin
            cyc();
            ta[i] = tick[a];
            ca[i] = clkout[a];
            tb[i] = tick[b];
            cb[i] = clkout[b];
        end
    endtask

    logic [15:0] ta, ca, tb2, cb;
    logic [3:0]  acc;
    int          n;

    initial begin
        // reset with every other input active; the reset-cycle transfer must vanish
        reset = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd9;
        calib = 1'b1; en = 4'hf;
        cyc(); cyc();
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_clkout", 32'(clkout), 32'h0);
        chk("rst_pend", 32'(pend), 32'h0);
        chk("rst_ready", 32'(cfg_ready), 32'h1);

        // ch0 at default divisor 4
        reset = 1'b0; cfg_valid = 1'b0; calib = 1'b0; en = 4'b0001;
        acc = '0;
        ta = '0; ca = '0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            ta[i] = tick[0];
            ca[i] = clkout[0];
            acc = acc | tick | clkout;
        end
        chk("div4_tick", 32'(ta[11:0]), 32'h888);
        chk("div4_clkout", 32'(ca[11:0]), 32'h999);
        chk("idle_chans", 32'(acc[3:1]), 32'h0);

        // load ch1 with 5 while it runs at 4
        en = 4'b0011; cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
        #1;
        chk("ready_idle", 32'(cfg_ready), 32'h1);
        cyc();
        cfg_valid = 1'b0;
        chk("pend1_set", 32'(pend), 32'h2);
        cyc(); cyc();
        chk("pend1_hold", 32'(pend[1]), 32'h1);
        cyc();
        chk("wrap1_tick", 32'(tick[1]), 32'h1);
        chk("wrap1_pend", 32'(pend[1]), 32'h0);
        rec(10, 1, 0, ta, ca, tb2, cb);
        chk("div5_tick", 32'(ta[9:0]), 32'h210);
        chk("div5_clkout", 32'(ca[9:0]), 32'h273);

        // back-to-back requests: the second waits and is not lost
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd7;
        cyc();
        cfg_div = 8'd2;
        #1;
        chk("ready_busy", 32'(cfg_ready), 32'h0);
        wait_tick(1, n);
        chk("period5_tail", 32'(n), 32'd4);
        chk("ready_after_wrap", 32'(cfg_ready), 32'h1);
        cyc();
        cfg_valid = 1'b0;
        chk("pend1_second", 32'(pend[1]), 32'h1);
        wait_tick(1, n);
        chk("period7", 32'(n), 32'd6);
        wait_tick(1, n);
        chk("period2_a", 32'(n), 32'd2);

        // divisor 0 stops the channel, divisor 1 restarts it at full rate
        cfg_valid = 1'b1; cfg_div = 8'd0;
        cyc();
        cfg_valid = 1'b0;
        wait_tick(1, n);
        chk("last_tick_before_stop", 32'(n), 32'd1);
        chk("stop_clkout_now", 32'(clkout[1]), 32'h0);
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            acc[0] = acc[0] | tick[1] | clkout[1];
        end
        chk("stopped", 32'(acc[0]), 32'h0);
        cfg_valid = 1'b1; cfg_div = 8'd1;
        cyc();
        cfg_valid = 1'b0;
        chk("div1_pend", 32'(pend[1]), 32'h1);
        cyc();
        chk("div1_applied", 32'(pend[1]), 32'h0);
        acc = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            cyc();
            acc[0] = acc[0] & tick[1] & clkout[1];
        end
        chk("div1_run", 32'(acc[0]), 32'h1);

        // ch0 and ch2 at divisor 4, offset by one cycle, then realigned
        wait_tick(0, n);
        cyc();
        en = 4'b0111;
        rec(8, 0, 2, ta, ca, tb2, cb);
        chk("skew_tick0", 32'(ta[7:0]), 32'h44);
        chk("skew_tick2", 32'(tb2[7:0]), 32'h88);
        calib = 1'b1;
        cyc();
        calib = 1'b0;
        chk("calib_tick", 32'(tick), 32'h0);
        chk("calib_clkout", 32'(clkout), 32'h0);
        rec(8, 0, 2, ta, ca, tb2, cb);
        chk("align_tick0", 32'(ta[7:0]), 32'h88);
        chk("align_tick2", 32'(tb2[7:0]), 32'h88);
        chk("align_clkout2", 32'(cb[7:0]), 32'h99);

        // transfer accepted on a wrap edge applies one wrap later
        cyc(); cyc(); cyc();
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
        cyc();
        cfg_valid = 1'b0;
        chk("wrapedge_tick", 32'(tick[0]), 32'h1);
        chk("wrapedge_pend", 32'(pend[0]), 32'h1);
        wait_tick(0, n);
        chk("old_period_kept", 32'(n), 32'd4);
        chk("applied_late", 32'(pend[0]), 32'h0);
        wait_tick(0, n);
        chk("period3", 32'(n), 32'd3);

        // reset mid-period with a pending divisor
        cyc();
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd9;
        cyc();
        cfg_valid = 1'b0;
        chk("pend2_set", 32'(pend), 32'h4);
        reset = 1'b1;
        cyc();
        chk("mid_rst_tick", 32'(tick), 32'h0);
        chk("mid_rst_clkout", 32'(clkout), 32'h0);
        chk("mid_rst_pend", 32'(pend), 32'h0);
        chk("mid_rst_ready", 32'(cfg_ready), 32'h1);
        reset = 1'b0; en = 4'b0001;
        wait_tick(0, n);
        chk("def_div_restored", 32'(n), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clkdiv_prog.md
CLKDIV_PROG -- requirements
Module: clkdiv_prog

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 8, divisor width in bits (2..16).
REQ-003 SHALL have parameter DEF_DIV, default 4, divisor every channel uses after reset (0..2^DIV_W-1).
REQ-004 SHALL have port hclkin  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cfg_valid  input  1  divisor-update request.
REQ-007 SHALL have port cfg_ready  output  1  update can be accepted this cycle.
REQ-008 SHALL have port cfg_ch  input  CH_W=max(1,clog2(NCH))  target channel.
REQ-009 SHALL have port cfg_div  input  DIV_W  new divisor.
REQ-010 SHALL have port calib  input  1  phase-realign all channels.
REQ-011 SHALL have port en  input  NCH  per-channel count enable.
REQ-012 SHALL have port tick  output  NCH  one-cycle pulse per divided period.
REQ-013 SHALL have port clkout  output  NCH  divided square wave, used as enable/data, never as a clock.
REQ-014 SHALL have port pend  output  NCH  channel holds an accepted, not-yet-applied divisor.

Function
REQ-015 Each channel SHALL hold cnt (DIV_W bits), div_cur, div_new and pend.
REQ-016 cfg_ready SHALL equal ~pend[cfg_ch] combinationally; with cfg_ch>=NCH it SHALL be 1, and the transfer SHALL be accepted and discarded.
REQ-017 A transfer SHALL occur when cfg_valid&cfg_ready; it SHALL set div_new=cfg_div and pend=1 on the next edge.
REQ-018 With en[i]=1, calib=0, div_cur>=1: cnt SHALL wrap to 0 when cnt>=div_cur-1, else increment by 1.
REQ-019 On a wrap with pend=1, div_cur SHALL take div_new and pend SHALL clear on the same edge.
REQ-020 With div_cur=0, the channel SHALL be stopped: cnt held 0, tick 0, clkout 0, and a pending divisor SHALL apply on the next edge.
REQ-021 tick[i] SHALL be registered: 1 in the cycle after the edge on which cnt wrapped, else 0.
REQ-022 clkout[i] SHALL be registered as (updated cnt < (div_cur+1)>>1).
REQ-023 Odd divisors SHALL therefore give a high phase one cycle longer than the low phase; div=1 SHALL give tick=1 every enabled cycle with clkout=1.
REQ-024 en[i]=0 SHALL freeze cnt and clkout[i], force tick[i]=0, and defer any pending update.
REQ-025 While calib=1, all cnt SHALL be 0 and all tick and clkout SHALL be 0.
REQ-026 While calib=1, any pending divisors SHALL be applied.
REQ-027 After calib falls, all channels with equal divisor SHALL be phase-identical.
REQ-028 A transfer accepted on the same edge as a wrap SHALL NOT apply at that wrap; it SHALL apply at the following wrap.
REQ-029 The period between ticks SHALL be exactly div_cur enabled cycles, with no short or long period across a divisor change.

Reset
REQ-030 On reset, outputs SHALL be cnt=0, div_cur=DEF_DIV, div_new=0, pend=0, tick=0, clkout=0, and cfg_ready=1.
REQ-031 Reset SHALL override calib, en and cfg_valid; a transfer in the reset cycle SHALL be lost.

Structure
REQ-032 Package clkdiv_pkg SHALL hold default NCH, DIV_W, DEF_DIV and the CH_W calculation function.
REQ-033 Sub-module clkdiv_chan SHALL implement one channel; it SHALL be instantiated NCH times in a generate loop.
REQ-034 The top level SHALL hold only the cfg decode and cfg_ready mux.

Verification
REQ-035 Reset, then en=4'b0001 with defaults: tick[0] SHALL pulse every 4 cycles and clkout[0] SHALL show 2 high / 2 low; other channels SHALL stay 0.
REQ-036 Load cfg_ch=1, cfg_div=5: pend[1]=1 until the next wrap, then tick spacing SHALL be 5 and clkout SHALL show 3 high / 2 low.
REQ-037 A second request to ch1 while pend[1]=1 SHALL see cfg_ready=0 and SHALL not be lost once accepted.
REQ-038 A request with cfg_div=0 SHALL stop the channel with tick=0 and clkout=0; a following cfg_div=1 SHALL apply next cycle with tick every cycle and clkout=1.
REQ-039 Pulsing calib for 1 cycle with ch0 div=4 and ch2 div=4 at different phases SHALL make tick[0] and tick[2] coincident afterwards.
REQ-040 A request accepted on a wrap edge, and reset asserted mid-period, SHALL follow REQ-028 and REQ-030 exactly.
